// File: rtl/axis_demux_4.sv
// axis_demux_4: AXI4-Stream 1-to-4 frame demultiplexer.
// Each whole frame is steered to the port chosen by `select`. `select` is
// sampled once, when the frame starts.
// A shared output register and a temp (skid) register allow one beat per
// cycle while keeping input_axis_tready registered.
// Optional feature: define AXIS_DEMUX_4_DROP_EN to add a `drop` input.
// `drop` is latched at frame start, and a frame latched with drop = 1 is
// accepted at full rate and discarded.
module axis_demux_4 #(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic [USER_WIDTH-1:0] input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_0_axis_tdata,
  output logic                  output_0_axis_tvalid,
  input  logic                  output_0_axis_tready,
  output logic                  output_0_axis_tlast,
  output logic [USER_WIDTH-1:0] output_0_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_1_axis_tdata,
  output logic                  output_1_axis_tvalid,
  input  logic                  output_1_axis_tready,
  output logic                  output_1_axis_tlast,
  output logic [USER_WIDTH-1:0] output_1_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_2_axis_tdata,
  output logic                  output_2_axis_tvalid,
  input  logic                  output_2_axis_tready,
  output logic                  output_2_axis_tlast,
  output logic [USER_WIDTH-1:0] output_2_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_3_axis_tdata,
  output logic                  output_3_axis_tvalid,
  input  logic                  output_3_axis_tready,
  output logic                  output_3_axis_tlast,
  output logic [USER_WIDTH-1:0] output_3_axis_tuser,
  input  logic                  enable,
  input  logic [1:0]            select
`ifdef AXIS_DEMUX_4_DROP_EN
  ,
  input  logic                  drop
`endif
);

  // Frame control state
  logic                  frame_reg, frame_next;
  logic [1:0]            select_reg, select_next;
  logic                  drop_reg, drop_next;
  logic                  tready_reg, tready_next;

  // Shared output register and skid register
  logic                  out_valid, tmp_valid;
  logic [DATA_WIDTH-1:0] out_data, tmp_data;
  logic                  out_last, tmp_last;
  logic [USER_WIDTH-1:0] out_user, tmp_user;

  logic                  drop_cur;
  logic [USER_WIDTH-1:0] user_in;
  logic [3:0]            port_ready;
  logic [3:0]            port_valid;
  logic                  sel_ready;
  logic                  accept;
  logic                  store;
  logic                  draining;
  logic                  buf_empty;
  logic                  early;

`ifdef AXIS_DEMUX_4_DROP_EN
  assign drop_cur = drop;
`else
  assign drop_cur = 1'b0;
`endif

  assign user_in    = (USER_ENABLE != 0) ? input_axis_tuser : '0;
  assign port_ready = {output_3_axis_tready, output_2_axis_tready,
                       output_1_axis_tready, output_0_axis_tready};

  // A beat only lands in the buffers when it is accepted and not discarded.
  assign accept    = input_axis_tvalid && tready_reg;
  assign store     = accept && !drop_reg;
  assign draining  = !out_valid || sel_ready;
  assign buf_empty = !out_valid && !tmp_valid;
  // Room for another beat next cycle without overflowing the skid register.
  assign early     = !tmp_valid && (!out_valid || sel_ready || !accept);

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg  <= 1'b0;
      select_reg <= 2'd0;
      drop_reg   <= 1'b0;
      tready_reg <= 1'b0;
    end else begin
      frame_reg  <= frame_next;
      select_reg <= select_next;
      drop_reg   <= drop_next;
      tready_reg <= tready_next;
    end
  end

  // Next-state: start frames, end them on tlast, compute the next input ready.
  // A new frame may start while the buffers drain only if it keeps the same
  // port. Otherwise the drain would be routed to the wrong port.
  always_comb begin
    frame_next  = frame_reg;
    select_next = select_reg;
    drop_next   = drop_reg;
    if (frame_reg) begin
      if (accept && input_axis_tlast) begin
        frame_next = 1'b0;
      end
    end else if (enable && input_axis_tvalid &&
                 (buf_empty || (select == select_reg))) begin
      frame_next  = 1'b1;
      select_next = select;
      drop_next   = drop_cur;
    end
    tready_next = frame_next && (drop_next || early);
  end

  // Output decode: only the latched port sees the shared valid
  always_comb begin
    port_valid             = 4'b0000;
    port_valid[select_reg] = out_valid;
    sel_ready              = port_ready[select_reg];
  end

  // Skid datapath: the output register drains first; the temp register refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= '0;
      tmp_valid <= 1'b0;
      tmp_data  <= '0;
      tmp_last  <= 1'b0;
      tmp_user  <= '0;
    end else if (draining) begin
      if (tmp_valid) begin
        out_valid <= 1'b1;
        out_data  <= tmp_data;
        out_last  <= tmp_last;
        out_user  <= tmp_user;
        tmp_valid <= 1'b0;
      end else if (store) begin
        out_valid <= 1'b1;
        out_data  <= input_axis_tdata;
        out_last  <= input_axis_tlast;
        out_user  <= user_in;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (store) begin
      tmp_valid <= 1'b1;
      tmp_data  <= input_axis_tdata;
      tmp_last  <= input_axis_tlast;
      tmp_user  <= user_in;
    end
  end

  assign input_axis_tready = tready_reg;

  assign output_0_axis_tvalid = port_valid[0];
  assign output_1_axis_tvalid = port_valid[1];
  assign output_2_axis_tvalid = port_valid[2];
  assign output_3_axis_tvalid = port_valid[3];

  assign output_0_axis_tdata = out_data;
  assign output_1_axis_tdata = out_data;
  assign output_2_axis_tdata = out_data;
  assign output_3_axis_tdata = out_data;

  assign output_0_axis_tlast = out_last;
  assign output_1_axis_tlast = out_last;
  assign output_2_axis_tlast = out_last;
  assign output_3_axis_tlast = out_last;

  assign output_0_axis_tuser = out_user;
  assign output_1_axis_tuser = out_user;
  assign output_2_axis_tuser = out_user;
  assign output_3_axis_tuser = out_user;

endmodule

// File: tb/tb_axis_demux_4.sv
// Self-checking bench for axis_demux_4: frames are issued by a driver, and
// their expected beats are pushed onto a scoreboard queue. A monitor pops
// and compares every output handshake.
module tb_axis_demux_4;

  localparam int BUDGET = 300;

  typedef struct {
    int       port;
    logic [7:0] data;
    logic     last;
    logic     user;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_user = 1'b0;
  logic       input_axis_tready;
  logic       enable = 1'b0;
  logic [1:0] select = 2'd0;
`ifdef AXIS_DEMUX_4_DROP_EN
  logic       drop_sig = 1'b0;
`endif
  logic [7:0] od [0:3];
  logic [3:0] ov, ol, ou;
  logic [3:0] rdy = 4'hF;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  bit   rand_rdy = 1'b0;
  bit   cur_drop = 1'b0;
  int   in_acc = 0;
  int   out_cnt = 0;

  always #5 clk = ~clk;

  axis_demux_4 #(.DATA_WIDTH(8), .USER_ENABLE(1), .USER_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_data), .input_axis_tvalid(in_valid),
    .input_axis_tready(input_axis_tready), .input_axis_tlast(in_last),
    .input_axis_tuser(in_user),
    .output_0_axis_tdata(od[0]), .output_0_axis_tvalid(ov[0]),
    .output_0_axis_tready(rdy[0]), .output_0_axis_tlast(ol[0]), .output_0_axis_tuser(ou[0]),
    .output_1_axis_tdata(od[1]), .output_1_axis_tvalid(ov[1]),
    .output_1_axis_tready(rdy[1]), .output_1_axis_tlast(ol[1]), .output_1_axis_tuser(ou[1]),
    .output_2_axis_tdata(od[2]), .output_2_axis_tvalid(ov[2]),
    .output_2_axis_tready(rdy[2]), .output_2_axis_tlast(ol[2]), .output_2_axis_tuser(ou[2]),
    .output_3_axis_tdata(od[3]), .output_3_axis_tvalid(ov[3]),
    .output_3_axis_tready(rdy[3]), .output_3_axis_tlast(ol[3]), .output_3_axis_tuser(ou[3]),
    .enable(enable), .select(select)
`ifdef AXIS_DEMUX_4_DROP_EN
    , .drop(drop_sig)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks AXIS rules.
  logic [3:0] pv = '0, pr = '0;
  logic [9:0] pd [0:3];
  always @(negedge clk) begin
    if (rst) begin
      pv = '0;
      in_acc = 0;
      out_cnt = 0;
    end else begin
      chk("one_valid", ($countones(ov) <= 1), 1);
      chk("buffered_le2", ((in_acc - out_cnt) <= 2), 1);
      for (int p = 0; p < 4; p++) begin
        if (pv[p] && !pr[p]) begin
          chk("hold_valid", ov[p], 1);
          chk("hold_beat", {od[p], ol[p], ou[p]}, pd[p]);
        end
        if (ov[p] && rdy[p]) begin
          out_cnt++;
          chk("sb_nonempty", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("port", p, e.port);
            chk("data", od[p], e.data);
            chk("last", ol[p], e.last);
            chk("user", ou[p], e.user);
          end
        end
        pd[p] = {od[p], ol[p], ou[p]};
      end
      pv = ov;
      pr = rdy;
      if (in_valid && input_axis_tready && !cur_drop) in_acc++;
    end
  end

  // Random downstream ready when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) for (int p = 0; p < 4; p++) rdy[p] = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u, output int waits);
    in_data = d;
    in_last = l;
    in_user = u;
    in_valid = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!input_axis_tready && waits < BUDGET);
    if (!input_axis_tready) chk("handshake_timeout", waits, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int dest, input int alt, input int len, input bit drp,
                            input bit gaps, input bit latchk,
                            input logic [7:0] first, input logic [7:0] step);
    int w;
    logic [63:0] umask;
    exp_t e;
    umask = {$urandom, $urandom};
    cur_drop = drp;
    select = dest[1:0];
    enable = 1'b1;
`ifdef AXIS_DEMUX_4_DROP_EN
    drop_sig = drp;
`endif
    if (!drp) begin
      for (int i = 0; i < len; i++) begin
        e.port = dest;
        e.data = first + 8'(i) * step;
        e.last = (i == len - 1);
        e.user = umask[i];
        sb.push_back(e);
      end
    end
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(first + 8'(i) * step, (i == len - 1), umask[i], w);
      if (latchk) chk("beat_wait", w, (i == 0) ? 2 : 1);
      if (i == 0) begin
        select = alt[1:0];
        enable = 1'($urandom_range(0, 1));
`ifdef AXIS_DEMUX_4_DROP_EN
        drop_sig = 1'($urandom_range(0, 1));
`endif
      end
    end
    @(negedge clk);
    chk("rdy_after_last", input_axis_tready, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", ov, 0);
    chk("rst_tready", input_axis_tready, 0);
    chk("rst_tdata", od[0], 0);
    chk("rst_tlast", ol, 0);
    chk("rst_tuser", ou, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic 3-beat frame to port 2, full speed
    send_frame(2, 2, 3, 0, 0, 1, 8'h11, 8'h11);

    // select changed mid-frame is ignored; next frame uses the new port
    send_frame(1, 3, 4, 0, 0, 1, 8'h40, 8'h01);
    send_frame(3, 3, 2, 0, 0, 1, 8'h70, 8'h01);

    // Backpressure on port 0 for 5 cycles mid-frame
    fork
      send_frame(0, 0, 10, 0, 0, 0, 8'h80, 8'h01);
      begin
        n = 0;
        for (int k = 0; k < BUDGET && n < 3; k++) begin
          @(negedge clk);
          if (in_valid && input_axis_tready) n++;
        end
        chk("bp_start", n, 3);
        @(posedge clk);
        #1;
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("bp_rdy_hold", input_axis_tready, 1);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_rdy_low", input_axis_tready, 0);
        end
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
      end
    join

    // enable low blocks frame start
    select = 2'd0;
    enable = 1'b0;
    in_data = 8'h55;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("en0_tready", input_axis_tready, 0);
      chk("en0_tvalid", ov, 0);
    end
    @(posedge clk);
    #1;
    send_frame(0, 1, 1, 0, 0, 1, 8'h5A, 8'h00);

    // Reset mid-frame with two beats buffered
    rdy = 4'h0;
    cur_drop = 1'b0;
    select = 2'd1;
    enable = 1'b1;
    send_beat(8'hA1, 1'b0, 1'b0, n);
    send_beat(8'hA2, 1'b0, 1'b0, n);
    in_data = 8'hA3;
    in_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", ov, 4'b0010);
    chk("pre_rst_tready", input_axis_tready, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", ov, 0);
    chk("mid_rst_tready", input_axis_tready, 0);
    chk("mid_rst_tdata", od[1], 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    rdy = 4'hF;
    @(posedge clk);
    #1;
    send_frame(3, 3, 3, 0, 0, 1, 8'hC0, 8'h03);

`ifdef AXIS_DEMUX_4_DROP_EN
    // Dropped frame: full rate, no output; next frame delivered
    send_frame(1, 1, 3, 1, 0, 1, 8'hD0, 8'h01);
    send_frame(1, 1, 2, 0, 0, 1, 8'hE0, 8'h01);
`endif

    // Randomized traffic with random downstream ready
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      bit drp;
      drp = 1'b0;
`ifdef AXIS_DEMUX_4_DROP_EN
      drp = ($urandom_range(0, 4) == 0);
`endif
      send_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(1, 6)), drp, 1, 0,
                 8'($urandom), 8'($urandom_range(1, 9)));
    end

    // Drain everything
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    rdy = 4'hF;
    got = 1'b0;
    for (int k = 0; k < BUDGET && !got; k++) begin
      @(negedge clk);
      got = (sb.size() == 0);
    end
    chk("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
